// File: rtl/bit_stream_pkg.sv
// bit_stream_pkg -- shared types and constants for the bit-serial adder/subtractor blocks.
// Rev 1.0
`default_nettype none

package bit_stream_pkg;

  localparam int BS_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NB   = 2'd1,
    BR   = 2'd2,
    DONE = 2'd3
  } bs_state_t;

endpackage

`default_nettype wire

// File: rtl/bit_sub_cell.sv
// bit_sub_cell -- combinational full subtractor: d = y - b - br_in, with borrow out.
// Rev 1.0
`default_nettype none

module bit_sub_cell (
  input  logic y,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = y ^ b ^ br_in;
  assign br_out = (~y & b) | (~(y ^ b) & br_in);

endmodule

`default_nettype wire

// File: rtl/bit_stream_sub_fsm.sv
// bit_stream_sub_fsm -- LSB-first serial subtractor D = Y - B with parallel capture of the frame.
// Rev 1.0
`default_nettype none

module bit_stream_sub_fsm
  import bit_stream_pkg::*;
#(
  parameter int WIDTH = BS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Y,
  input  logic             B,
  output logic             D,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_word,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  bs_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          consume;
  logic          last_bit;
  logic          br_in;
  logic          d_bit;
  logic          br_bit;

  bit_sub_cell u_cell (
    .y      (Y),
    .b      (B),
    .br_in  (br_in),
    .d      (d_bit),
    .br_out (br_bit)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    consume  = 1'b0;
    last_bit = 1'b0;
    br_in    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          consume  = 1'b1;
          cnt_nx   = CW'(1);
          state_nx = br_bit ? BR : NB;
        end else begin
          state_nx = IDLE;
        end
      end
      NB, BR: begin
        // start is deliberately ignored here: a frame is never restarted mid-way
        consume = 1'b1;
        br_in   = (state == BR);
        if (cnt == LAST) begin
          last_bit = 1'b1;
          cnt_nx   = '0;
          state_nx = DONE;
        end else begin
          cnt_nx   = cnt + CW'(1);
          state_nx = br_bit ? BR : NB;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      D          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff_word  <= '0;
      borrow_out <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      D     <= consume ? d_bit : 1'b0;
      busy  <= (state_nx == NB) || (state_nx == BR);
      done  <= (state_nx == DONE);
      // LSB-first stream: after WIDTH shifts bit 0 has reached the LSB
      if (consume) begin
        diff_word <= {d_bit, diff_word[WIDTH-1:1]};
      end
      if (last_bit) begin
        borrow_out <= br_bit;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/bit_stream_sub_fsm.md
# bit_stream_sub_fsm

Bit-serial, LSB-first subtractor: the inverse of the bitstream adder. It consumes a sum stream `Y` and an operand stream `B`, emits the serial difference `D = Y - B` (recovering `A`), and deserializes the frame into a parallel word. A fixed-length frame of `WIDTH` bits is delimited by `start`, and completion is flagged with `done` and `borrow_out`. It sits downstream of the adder for loopback checking, and wherever a serial subtract-and-capture is needed.

## Interface
- `WIDTH`, default 8: frame length in bits; legal range ≥ 2.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame start; the bit pair on `Y`/`B` in this cycle is bit 0.
- `Y`  in  1  minuend stream, LSB first.
- `B`  in  1  subtrahend stream, LSB first.
- `D`  out  1  registered serial difference bit.
- `busy`  out  1  high while bits 1..WIDTH-1 are being consumed.
- `done`  out  1  one-cycle pulse marking frame completion.
- `diff_word`  out  WIDTH  captured difference, bit k = difference bit k.
- `borrow_out`  out  1  final borrow; 1 means Y < B, unsigned.

## Operation
- States: IDLE, NB (no borrow pending), BR (borrow pending), DONE.
- Per-bit arithmetic:
  - `d = Y ^ B ^ br`
  - `br_next = (~Y & B) | (~(Y ^ B) & br)`
  - Bit 0 uses `br = 0`.
- IDLE or DONE with `start = 1`:
  - Consume bit 0 and load bit counter = 1.
  - Go to BR if `br_next` else NB.
  - Shift `d` into `diff_word` MSB, right-shifting the rest.
- IDLE or DONE with `start = 0`: stay in IDLE (DONE → IDLE); no sampling.
- NB/BR:
  - Consume one bit per cycle, using `br = (state == BR)`.
  - Shift `d` into `diff_word`, increment the counter.
  - Next state is NB/BR per `br_next`.
  - After the bit with counter = WIDTH-1, go to DONE and latch `borrow_out = br_next`.
- `start` in NB/BR is ignored; the frame is not restarted.
- DONE lasts exactly one cycle. `start` in the DONE cycle is honoured, giving back-to-back frames with no gap.
- After `done`, `diff_word` and `borrow_out` hold until the next frame's bit 0 is consumed.
- `D`: registered; equals `d` of the bit consumed in the previous cycle, else 0.
- Reset (any state, including mid-frame):
  - State IDLE, counter 0.
  - Outputs: `D = 0`, `busy = 0`, `done = 0`, `diff_word = 0`, `borrow_out = 0`.
  - A partial frame is discarded; no `done` is produced for it.
- Arithmetic: modulo 2^WIDTH; `borrow_out` carries the underflow.

## Timing
- t0 = cycle `start` is sampled; bit k is sampled at t0+k.
- `D` for bit k is valid at t0+k+1 (one-cycle latency).
- `busy` is high t0+1 .. t0+WIDTH-1 and low at t0 and at t0+WIDTH.
- `done = 1` at t0+WIDTH only.
  - `diff_word` and `borrow_out` are valid from t0+WIDTH.
  - The last `D` bit is also valid at t0+WIDTH.
- Back-to-back frames: a new t0 may equal t0+WIDTH of the previous frame.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `bit_stream_pkg`:
  - state enum `bs_state_t` (IDLE, NB, BR, DONE)
  - default frame width constant `BS_WIDTH = 8`
  - adder and subtractor both import it.
- Sub-module `bit_sub_cell`: combinational full subtractor (`Y`, `B`, `br_in` → `d`, `br_out`), reusable by later serial-arithmetic blocks.
- Top level holds:
  - FSM
  - `$clog2(WIDTH)` counter
  - shift register
  - output registers

## Test plan
- WIDTH = 8, `Y = 0x5A`, `B = 0x23` → `D` stream is LSB-first 0x37; `diff_word = 0x37`, `borrow_out = 0`, `done` at t0+8, `busy` high t0+1..t0+7.
- `Y = 0x10`, `B = 0x20` → `diff_word = 0xF0`, `borrow_out = 1`. `Y = 0x00`, `B = 0x01` → `0xFF`, `borrow_out = 1`. `Y = B = 0xA5` → `0x00`, `borrow_out = 0`.
- Back-to-back: frame 1 (`0x5A - 0x23`), then `start` in its DONE cycle with `0x10 - 0x20` → `done` at t0+8 (`0x37`) and t0+16 (`0xF0`); no idle gap.
- `start` pulsed at t0+3 mid-frame → ignored; the result still equals frame 1, `done` at t0+8 only.
- `rst` asserted at t0+4 → next cycle all outputs are 0, state IDLE, no `done`. A fresh frame after release computes correctly.
- Loopback: random `A`, `B` through the adder, its `Y` with a delay-aligned `B` into this block → `diff_word == A` for 1000 random pairs.
